hdb3_decode: RTL
================

Name: hdb3_decode

Overview:
- Receive-side counterpart of the HDB3 line encoder. Accepts one 2-bit ternary HDB3 symbol per clock and recovers the original NRZ bit stream.
- Detects violation (V) pulses and restores each 000V / B00V substitution to 0000.
- Flags line-code errors and counts violations.
- Sits after the line interface or encoder in loopback benches; the output feeds downstream NRZ logic.

Parameters:
- P_POS_CODE, 2'b01, code for a positive pulse (+1).
- P_NEG_CODE, 2'b10, code for a negative pulse (-1). 2'b00 is zero; any other value is illegal.
- P_CNT_W, 16, width of the violation counter.

Ports:
- i_clk, input, 1, system clock; one symbol per rising edge.
- i_rst, input, 1, asynchronous active-high reset.
- i_hdb3_code, input, 2, ternary symbol sampled every rising edge.
- o_data, output, 1, decoded NRZ bit.
- o_valid, output, 1, high once the pipeline is filled since reset.
- o_code_err, output, 1, one-cycle pulse per detected line-code error.
- o_viol_cnt, output, P_CNT_W, saturating count of V pulses detected.

Behaviour:
- Reset (async, i_rst=1): o_data=0, o_valid=0, o_code_err=0, o_viol_cnt=0. Also cleared: shift register sr[3:0], r_last_pol, r_pol_ok, r_last_vpol, r_vpol_ok, fill counter.
- Mark: i_hdb3_code equals P_POS_CODE or P_NEG_CODE. Polarity is + for P_POS_CODE, - for P_NEG_CODE.
- V detection: a mark is V when r_pol_ok=1 and its polarity equals r_last_pol.
  - The first mark after reset is always a normal mark.
  - Every mark, including V, updates r_last_pol and sets r_pol_ok.
- Pipeline: sr[0] is the newest symbol. Each edge, o_data <= sr[3] and sr <= {sr[2:0], b}.
  - b=1 for a non-V mark; b=0 for zero, V, or illegal.
  - On V, sr is loaded with 4'b0000. This clears the three prior symbols (k-1..k-3) and enters the V as 0, so B00V decodes as 0000.
  - o_data is unaffected that cycle; it holds symbol k-4.
- Latency: a symbol sampled at edge k appears on o_data after edge k+4.
- o_valid:
  - A 3-bit fill counter increments per edge and saturates at 4.
  - o_valid is registered: it rises on the edge where the counter reaches 4, which is the 4th edge after reset release.
  - Remains 1 until reset.
- o_code_err is registered and asserted for one cycle, on the edge after the offending symbol, when any of these occur:
  - (a) i_hdb3_code is illegal (2'b11). The symbol is treated as 0 and does not update polarity state.
  - (b) V detected while symbol k-1 or k-2 was a mark, checked on raw input history before substitution. Substitution is still applied.
  - (c) V detected with r_vpol_ok=1 and its polarity equal to r_last_vpol (consecutive V not alternating). Each V updates r_last_vpol and sets r_vpol_ok.
  - Multiple conditions on one symbol still produce a single-cycle pulse.
- o_viol_cnt: increments by 1 per V, including erroneous V. Saturates at all-ones with no wrap.
- Raw history: a 2-entry record of "was mark" for k-1 and k-2 is kept for error check (b). It is cleared by reset.
- Reset mid-stream: all state clears immediately, and up to 4 in-flight bits are discarded. After release, decoding restarts with the first-mark rule and o_valid low for 4 edges.

Test Plan:
- Fill/latency: release reset with input 00 continuously, then 01 once. Required: o_valid rises on the 4th edge after release; o_data=1 exactly 4 edges after the 01 is sampled; o_code_err stays 0.
- 000V: codes 01,00,00,00,01,10. Required: decoded o_data = 1,0,0,0,0,1; o_viol_cnt=1; no error.
- B00V: codes 01,10,01,00,00,01,10. Required: decoded 1,1,0,0,0,0,1 (the B mark is cleared); o_viol_cnt=1; no error.
- Illegal and bad V: code 11 gives an o_code_err pulse, decodes as 0, and leaves polarity unchanged. Codes 01,10,00,10 give the V at the last symbol with k-2 a mark: o_code_err pulses once and o_viol_cnt increments.
- Non-alternating V: codes 01,00,00,00,01,00,00,00,01. Required: the second V (+ again) raises o_code_err; o_viol_cnt=2.
- Reset mid-operation and saturation:
  - Assert i_rst during a B00V sequence. Required: all outputs 0 immediately and o_valid low for 4 edges after release.
  - Force 2^P_CNT_W+3 V events (P_CNT_W=4 build). Required: o_viol_cnt holds 4'hF.

Source files
------------

// File: rtl/hdb3_decode.sv
// HDB3 receive decoder: turns ternary line symbols back into NRZ bits by undoing
// 000V/B00V substitutions, and reports line-code errors and a saturating V count.
module hdb3_decode #(
  parameter logic [1:0] P_POS_CODE = 2'b01,
  parameter logic [1:0] P_NEG_CODE = 2'b10,
  parameter int         P_CNT_W    = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_hdb3_code,
  output logic               o_data,
  output logic               o_valid,
  output logic               o_code_err,
  output logic [P_CNT_W-1:0] o_viol_cnt
);

  localparam logic [P_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [P_CNT_W-1:0] CNT_ONE = {{(P_CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [P_CNT_W-1:0] sat_inc(input logic [P_CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic       is_pos, is_neg, is_mark, is_illegal, is_v, bit_in, err_nxt;
  logic [3:0] sr, sr_nxt;
  logic       r_last_pol, r_pol_ok, r_last_vpol, r_vpol_ok;
  logic [1:0] r_mark_hist;
  logic [2:0] fill_cnt;

  // Stage 0: classify the incoming symbol against the polarity history
  always_comb begin
    is_pos     = (i_hdb3_code == P_POS_CODE);
    is_neg     = (i_hdb3_code == P_NEG_CODE);
    is_mark    = is_pos | is_neg;
    is_illegal = !is_mark && (i_hdb3_code != 2'b00);
    is_v       = is_mark && r_pol_ok && (is_pos == r_last_pol);
    bit_in     = is_mark && !is_v;
    // A V wipes the three bits behind it, so both 000V and B00V come out as 0000.
    sr_nxt     = is_v ? 4'b0000 : {sr[2:0], bit_in};
    // r_mark_hist is raw input history, so a B pulse just before the V still counts.
    err_nxt    = is_illegal
               | (is_v & (|r_mark_hist))
               | (is_v & r_vpol_ok & (is_pos == r_last_vpol));
  end

  // Stage 1..4: substitution shift register and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr          <= 4'b0000;
      o_data      <= 1'b0;
      o_valid     <= 1'b0;
      o_code_err  <= 1'b0;
      o_viol_cnt  <= '0;
      r_last_pol  <= 1'b0;
      r_pol_ok    <= 1'b0;
      r_last_vpol <= 1'b0;
      r_vpol_ok   <= 1'b0;
      r_mark_hist <= 2'b00;
      fill_cnt    <= 3'd0;
    end else begin
      o_data      <= sr[3];
      sr          <= sr_nxt;
      o_code_err  <= err_nxt;
      r_mark_hist <= {r_mark_hist[0], is_mark};
      if (fill_cnt != 3'd4) fill_cnt <= fill_cnt + 3'd1;
      o_valid     <= o_valid | (fill_cnt == 3'd3);
      if (is_mark) begin
        r_last_pol <= is_pos;
        r_pol_ok   <= 1'b1;
      end
      if (is_v) begin
        r_last_vpol <= is_pos;
        r_vpol_ok   <= 1'b1;
        o_viol_cnt  <= sat_inc(o_viol_cnt);
      end
    end
  end

endmodule
